// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_hazard_stage
// Brief    : ID/EX pipeline register with load-use bubble and multi-cycle hold
//            control. Optional stall counter enabled by HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_hazard_stage #(
    parameter int CW          = 22,
    parameter int LOAD_BIT    = 21,
    parameter int RF_EN_BIT   = 20,
    parameter int DEST_RD_BIT = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] ctrl_in,
    input  logic [4:0]    rs_in,
    input  logic [4:0]    rt_in,
    input  logic [4:0]    rd_in,
    input  logic [15:0]   imm16_in,
    input  logic [8:0]    pc_in,
    input  logic          uses_rs,
    input  logic          uses_rt,
    input  logic          ex_busy,
    input  logic          flush,
    output logic [CW-1:0] ctrl_out,
    output logic [4:0]    rs_out,
    output logic [4:0]    rt_out,
    output logic [4:0]    dest_out,
    output logic [15:0]   imm16_out,
    output logic [8:0]    pc_out,
    output logic          pc_le,
    output logic          ifid_le,
    output logic          mux_s,
    output logic [1:0]    state_out
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]   stall_count
`endif
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_ctrl;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [4:0]    r_dest;
    logic [15:0]   r_imm16;
    logic [8:0]    r_pc;

    logic [1:0]    w_next_state;
    logic          w_load;
    logic          w_zero_ctrl;
    logic          w_hz;
    logic          w_bubble_req;
    logic [4:0]    w_dest;

    // Only a load still sitting in ID/EX can supply stale data to the ID reader.
    assign w_hz = r_ctrl[LOAD_BIT] & r_ctrl[RF_EN_BIT] & (r_dest != 5'd0) &
                  ((uses_rs & (rs_in == r_dest)) | (uses_rt & (rt_in == r_dest)));

    assign w_dest       = ctrl_in[DEST_RD_BIT] ? rd_in : rt_in;
    assign w_bubble_req = (r_state != ST_HOLD) & ~ex_busy & ~flush & w_hz;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_zero_ctrl  = 1'b0;
        case (r_state)
            ST_RUN, ST_BUBBLE: begin
                if (ex_busy) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_load = 1'b1;
                    if (flush) begin
                        w_zero_ctrl  = 1'b1;
                        w_next_state = ST_RUN;
                    end else if (w_hz) begin
                        w_zero_ctrl  = 1'b1;
                        w_next_state = ST_BUBBLE;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
            end
            ST_HOLD: begin
                w_next_state = ex_busy ? ST_HOLD : ST_RUN;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_ctrl  <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_dest  <= '0;
            r_imm16 <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_ctrl  <= w_zero_ctrl ? '0 : ctrl_in;
                r_rs    <= rs_in;
                r_rt    <= rt_in;
                r_dest  <= w_dest;
                r_imm16 <= imm16_in;
                r_pc    <= pc_in;
            end
        end
    end

    // Upstream must freeze whenever ID/EX does not consume the ID instruction.
    assign pc_le     = (r_state != ST_HOLD) & ~ex_busy & ~w_bubble_req;
    assign ifid_le   = pc_le;
    assign mux_s     = w_bubble_req;

    assign ctrl_out  = r_ctrl;
    assign rs_out    = r_rs;
    assign rt_out    = r_rt;
    assign dest_out  = r_dest;
    assign imm16_out = r_imm16;
    assign pc_out    = r_pc;
    assign state_out = r_state;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (((r_state == ST_BUBBLE) || (r_state == ST_HOLD)) &&
                     (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_hazard_stage
// Brief    : Directed self-checking bench for id_ex_hazard_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_hazard_stage;

    localparam logic [21:0] c_LW_CTRL  = 22'h300000;  // load + rf_en, dest=rt
    localparam logic [21:0] c_ADD_CTRL = 22'h180123;  // rf_en, dest=rd

    logic        clk;
    logic        reset;
    logic [21:0] ctrl_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [15:0] imm16_in;
    logic [8:0]  pc_in;
    logic        uses_rs, uses_rt, ex_busy, flush;
    logic [21:0] ctrl_out;
    logic [4:0]  rs_out, rt_out, dest_out;
    logic [15:0] imm16_out;
    logic [8:0]  pc_out;
    logic        pc_le, ifid_le, mux_s;
    logic [1:0]  state_out;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    id_ex_hazard_stage dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl_in   (ctrl_in),
        .rs_in     (rs_in),
        .rt_in     (rt_in),
        .rd_in     (rd_in),
        .imm16_in  (imm16_in),
        .pc_in     (pc_in),
        .uses_rs   (uses_rs),
        .uses_rt   (uses_rt),
        .ex_busy   (ex_busy),
        .flush     (flush),
        .ctrl_out  (ctrl_out),
        .rs_out    (rs_out),
        .rt_out    (rt_out),
        .dest_out  (dest_out),
        .imm16_out (imm16_out),
        .pc_out    (pc_out),
        .pc_le     (pc_le),
        .ifid_le   (ifid_le),
        .mux_s     (mux_s),
        .state_out (state_out)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [21:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [8:0] pc,
                         input logic urs, input logic urt);
        ctrl_in  = c;
        rs_in    = rs;
        rt_in    = rt;
        rd_in    = rd;
        imm16_in = imm;
        pc_in    = pc;
        uses_rs  = urs;
        uses_rt  = urt;
    endtask

    initial begin
        // Reset held with random inputs
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(22'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  16'($urandom), 9'($urandom), 1'($urandom), 1'($urandom));
            ex_busy = 1'($urandom);
            flush   = 1'($urandom);
            tick();
        end
        chk("rst_ctrl_held", 32'(ctrl_out), 32'h0);
        drive(22'h0, 5'd0, 5'd0, 5'd0, 16'h0, 9'h0, 1'b0, 1'b0);
        ex_busy = 1'b0;
        flush   = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_ctrl",  32'(ctrl_out),  32'h0);
        chk("rst_rs",    32'(rs_out),    32'h0);
        chk("rst_rt",    32'(rt_out),    32'h0);
        chk("rst_dest",  32'(dest_out),  32'h0);
        chk("rst_imm",   32'(imm16_out), 32'h0);
        chk("rst_pc",    32'(pc_out),    32'h0);
        chk("rst_state", 32'(state_out), 32'h0);
        chk("rst_pc_le", 32'(pc_le),     32'h1);
        chk("rst_ifid",  32'(ifid_le),   32'h1);
        chk("rst_mux",   32'(mux_s),     32'h0);
        tick();

        // Load to r0 followed by a use of r0: no stall
        drive(c_LW_CTRL, 5'd3, 5'd0, 5'd11, 16'h0020, 9'h001, 1'b1, 1'b0);
        tick();
        chk("r0_ctrl", 32'(ctrl_out), 32'(c_LW_CTRL));
        chk("r0_dest", 32'(dest_out), 32'h0);
        drive(c_ADD_CTRL, 5'd0, 5'd0, 5'd12, 16'h0021, 9'h002, 1'b1, 1'b1);
        #1;
        chk("r0_pc_le", 32'(pc_le), 32'h1);
        chk("r0_mux",   32'(mux_s), 32'h0);
        tick();
        chk("r0_state", 32'(state_out), 32'h0);
        chk("r0_ctrl2", 32'(ctrl_out),  32'(c_ADD_CTRL));
        chk("r0_dest2", 32'(dest_out),  32'd12);

        // Load to r8: only a register actually read causes a hazard
        drive(c_LW_CTRL, 5'd1, 5'd8, 5'd2, 16'h0030, 9'h003, 1'b1, 1'b0);
        tick();
        drive(c_ADD_CTRL, 5'd8, 5'd8, 5'd4, 16'h0031, 9'h004, 1'b0, 1'b0);
        #1;
        chk("unused_pc_le", 32'(pc_le), 32'h1);
        uses_rt = 1'b1;
        #1;
        chk("rt_hz_pc_le", 32'(pc_le),   32'h0);
        chk("rt_hz_mux",   32'(mux_s),   32'h1);
        uses_rt = 1'b0;
        tick();
        chk("unused_state", 32'(state_out), 32'h0);

        // Load-use on r5: one bubble
        drive(c_LW_CTRL, 5'd2, 5'd5, 5'd9, 16'h0010, 9'h004, 1'b1, 1'b0);
        tick();
        chk("lu_ctrl", 32'(ctrl_out),  32'(c_LW_CTRL));
        chk("lu_dest", 32'(dest_out),  32'd5);
        chk("lu_imm",  32'(imm16_out), 32'h0010);
        drive(c_ADD_CTRL, 5'd5, 5'd6, 5'd7, 16'h0011, 9'h005, 1'b1, 1'b1);
        #1;
        chk("lu_pc_le", 32'(pc_le),   32'h0);
        chk("lu_ifid",  32'(ifid_le), 32'h0);
        chk("lu_mux",   32'(mux_s),   32'h1);
        tick();
        chk("lu_bub_ctrl",  32'(ctrl_out),  32'h0);
        chk("lu_bub_state", 32'(state_out), 32'h1);
        chk("lu_bub_rs",    32'(rs_out),    32'd5);
        chk("lu_bub_pc_le", 32'(pc_le),     32'h1);
        tick();
        chk("lu_add_ctrl",  32'(ctrl_out),  32'(c_ADD_CTRL));
        chk("lu_add_dest",  32'(dest_out),  32'd7);
        chk("lu_add_pc",    32'(pc_out),    32'h005);
        chk("lu_add_state", 32'(state_out), 32'h0);

        // Multi-cycle hold for three ex_busy cycles
        ex_busy = 1'b1;
        tick();
        chk("hold_state1", 32'(state_out), 32'h2);
        drive(22'h0ABCDE, 5'd31, 5'd30, 5'd29, 16'hBEEF, 9'h1FF, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("hold_pc_le", 32'(pc_le),   32'h0);
        chk("hold_ifid",  32'(ifid_le), 32'h0);
        chk("hold_mux",   32'(mux_s),   32'h0);
        tick();
        flush = 1'b0;
        chk("hold_state2", 32'(state_out), 32'h2);
        chk("hold_ctrl2",  32'(ctrl_out),  32'(c_ADD_CTRL));
        tick();
        chk("hold_state3", 32'(state_out), 32'h2);
        chk("hold_ctrl3",  32'(ctrl_out),  32'(c_ADD_CTRL));
        chk("hold_pc3",    32'(pc_out),    32'h005);
        chk("hold_imm3",   32'(imm16_out), 32'h0011);
        ex_busy = 1'b0;
        tick();
        chk("hold_exit_state", 32'(state_out), 32'h0);
        chk("hold_exit_ctrl",  32'(ctrl_out),  32'(c_ADD_CTRL));
`ifdef HAZARD_STATS_EN
        chk("stats_count4", 32'(stall_count), 32'd4);
`endif

        // Flush squashes a valid control word
        drive(22'h3FFFFF, 5'd10, 5'd11, 5'd12, 16'h1234, 9'h020, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_pc_le", 32'(pc_le), 32'h1);
        tick();
        chk("fl_ctrl",  32'(ctrl_out),  32'h0);
        chk("fl_rs",    32'(rs_out),    32'd10);
        chk("fl_dest",  32'(dest_out),  32'd12);
        chk("fl_state", 32'(state_out), 32'h0);

        // Flush beats a pending load-use hazard
        flush = 1'b0;
        drive(c_LW_CTRL, 5'd1, 5'd5, 5'd3, 16'h0040, 9'h021, 1'b0, 1'b0);
        tick();
        drive(c_ADD_CTRL, 5'd5, 5'd1, 5'd2, 16'h0041, 9'h022, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("flhz_pc_le", 32'(pc_le), 32'h1);
        chk("flhz_mux",   32'(mux_s), 32'h0);
        tick();
        chk("flhz_ctrl",  32'(ctrl_out),  32'h0);
        chk("flhz_state", 32'(state_out), 32'h0);
        flush = 1'b0;

        // Asynchronous reset in the middle of a hold
        drive(c_ADD_CTRL, 5'd4, 5'd4, 5'd4, 16'h0050, 9'h030, 1'b0, 1'b0);
        tick();
        ex_busy = 1'b1;
        tick();
        tick();
        chk("mid_hold_state", 32'(state_out), 32'h2);
        #2;
        reset   = 1'b0;
        ex_busy = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state_out), 32'h0);
        chk("mid_rst_ctrl",  32'(ctrl_out),  32'h0);
        chk("mid_rst_pc_le", 32'(pc_le),     32'h1);
`ifdef HAZARD_STATS_EN
        chk("mid_rst_count", 32'(stall_count), 32'h0);
`endif
        #3;
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
